// File: rtl/warning_annunciator.sv
// Dashboard-side annunciator: timed chime, rotating warning-code display and ack mute.
// Optional build macro PRI1_NOMUTE_EN: acknowledge cannot silence a priority-1 warning.
module warning_annunciator #(
  parameter int TICK_DIV = 1000,
  parameter int BEEP_P1  = 2,
  parameter int BEEP_P2  = 8,
  parameter int DWELL    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] warn_vec,
  input  logic       warn_pri1,
  input  logic       warn_pri2,
  input  logic       ack,
  output logic       chime,
  output logic [2:0] disp_code,
  output logic       muted
);

  // state | meaning
  // IDLE  | no warning active, outputs quiet
  // ALERT | warning active, chime pattern running
  // MUTED | warning active, chime silenced by driver acknowledge

  localparam int BMAX = (BEEP_P1 > BEEP_P2) ? BEEP_P1 : BEEP_P2;
  localparam int PW   = $clog2(TICK_DIV);
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;
  localparam int DW   = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, ALERT, MUTED} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [BW-1:0] beep_cnt, beep_nx, h_lim;
  logic [DW-1:0] dwell_cnt, dwell_nx;
  logic [1:0]    hsel, hsel_q;
  logic          ack_q, ack_rise, ack_mute;
  logic [6:0]    warn_q;
  logic          new_warn, any_warn, shown_set;
  logic [7:0]    warn_ext;
  logic          chime_nx, muted_nx;
  logic [2:0]    disp_nx, disp_adv;

  // Next set bit strictly above the current code, wrapping to the lowest set bit.
  function automatic logic [2:0] next_code(input logic [6:0] v, input logic [2:0] cur);
    logic [2:0] first, nxt;
    logic       have_first, have_nxt;
    first = 3'd0;
    nxt = 3'd0;
    have_first = 1'b0;
    have_nxt = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (v[i]) begin
        if (!have_first) begin
          first = 3'(i + 1);
          have_first = 1'b1;
        end
        if (!have_nxt && ((i + 1) > int'(cur))) begin
          nxt = 3'(i + 1);
          have_nxt = 1'b1;
        end
      end
    end
    return have_nxt ? nxt : first;
  endfunction

  assign tick     = (pre_cnt == PW'(TICK_DIV - 1));
  assign any_warn = |warn_vec;
  assign new_warn = |(warn_vec & ~warn_q);
  assign ack_rise = ack & ~ack_q;
`ifdef PRI1_NOMUTE_EN
  assign ack_mute = ack_rise & ~warn_pri1;
`else
  assign ack_mute = ack_rise;
`endif
  assign hsel      = warn_pri1 ? 2'd1 : (warn_pri2 ? 2'd2 : 2'd0);
  assign h_lim     = warn_pri1 ? BW'(BEEP_P1 - 1) : BW'(BEEP_P2 - 1);
  assign warn_ext  = {warn_vec, 1'b0};
  assign shown_set = warn_ext[disp_code];
  assign disp_adv  = next_code(warn_vec, disp_code);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    chime_nx = 1'b0;
    beep_nx  = '0;
    disp_nx  = 3'd0;
    dwell_nx = '0;
    case (state)
      IDLE:  if (any_warn) state_nx = ALERT;
      ALERT: begin
        if (!any_warn)     state_nx = IDLE;
        else if (ack_mute) state_nx = MUTED;
      end
      MUTED: begin
        if (!any_warn)      state_nx = IDLE;
        else if (new_warn)  state_nx = ALERT;
`ifdef PRI1_NOMUTE_EN
        else if (warn_pri1) state_nx = ALERT;
`endif
      end
      default: state_nx = IDLE;
    endcase

    // Entering ALERT or changing priority restarts the beep phase high.
    if (state_nx == ALERT && hsel != 2'd0) begin
      if (state != ALERT || hsel != hsel_q) begin
        chime_nx = 1'b1;
      end else if (tick && beep_cnt == h_lim) begin
        chime_nx = ~chime;
      end else if (tick) begin
        chime_nx = chime;
        beep_nx  = beep_cnt + 1'b1;
      end else begin
        chime_nx = chime;
        beep_nx  = beep_cnt;
      end
    end

    if (state_nx != IDLE) begin
      if (state == IDLE || !shown_set) begin
        disp_nx = disp_adv;
      end else if (tick && dwell_cnt == DW'(DWELL - 1)) begin
        disp_nx = disp_adv;
      end else if (tick) begin
        disp_nx  = disp_code;
        dwell_nx = dwell_cnt + 1'b1;
      end else begin
        disp_nx  = disp_code;
        dwell_nx = dwell_cnt;
      end
    end

    muted_nx = (state_nx == MUTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt   <= '0;
      beep_cnt  <= '0;
      dwell_cnt <= '0;
      hsel_q    <= 2'd0;
      ack_q     <= 1'b0;
      warn_q    <= 7'd0;
      chime     <= 1'b0;
      disp_code <= 3'd0;
      muted     <= 1'b0;
    end else begin
      pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
      beep_cnt  <= beep_nx;
      dwell_cnt <= dwell_nx;
      hsel_q    <= hsel;
      ack_q     <= ack;
      warn_q    <= warn_vec;
      chime     <= chime_nx;
      disp_code <= disp_nx;
      muted     <= muted_nx;
    end
  end

endmodule

// File: tb/tb_warning_annunciator.sv
// Scoreboard bench for warning_annunciator: expected outputs are queued per clock
// cycle by the stimulus and compared by an independent negedge monitor.
module tb_warning_annunciator;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] warn_vec;
  logic       warn_pri1, warn_pri2, ack;
  logic       chime, muted;
  logic [2:0] disp_code;

  int cyc = -1;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic       chime;
    logic [2:0] code;
    logic       muted;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  warning_annunciator #(.TICK_DIV(4), .BEEP_P1(1), .BEEP_P2(2), .DWELL(3)) dut (
    .clk(clk), .rst(rst), .warn_vec(warn_vec), .warn_pri1(warn_pri1),
    .warn_pri2(warn_pri2), .ack(ack), .chime(chime), .disp_code(disp_code), .muted(muted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_check cyc=%0d (now %0d)", e.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      checks++;
      if ({chime, disp_code, muted} !== {e.chime, e.code, e.muted}) begin
        errors++;
        $display("FAIL outputs cyc=%0d chime/code/muted got %b/%0d/%b want %b/%0d/%b",
                 cyc, chime, disp_code, muted, e.chime, e.code, e.muted);
      end
    end
  end

  task automatic push(input int c, input logic ch, input logic [2:0] d, input logic m);
    exp_t x;
    x.cyc = c;
    x.chime = ch;
    x.code = d;
    x.muted = m;
    sb.push_back(x);
  endtask

  task automatic wait_cyc(input int k);
    int n = 0;
    while (cyc != k && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cyc != k) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout got cyc=%0d want %0d", cyc, k);
    end
  endtask

  initial begin
    rst = 1'b1;
    warn_vec = 7'd0;
    warn_pri1 = 1'b0;
    warn_pri2 = 1'b0;
    ack = 1'b0;

    // quiet after reset
    for (int k = 0; k <= 20; k++) push(k, 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cyc(20);

    // seat warning, priority 2: 8-cycle half period
    for (int k = 21; k <= 51; k++) begin
      if (k < 48) push(k, (k < 28) || (k >= 36 && k < 44), 3'd1, 1'b0);
      else        push(k, 1'b0, 3'd0, 1'b0);
    end
    warn_vec = 7'b0000001;
    warn_pri2 = 1'b1;
    wait_cyc(47);
    warn_vec = 7'd0;
    warn_pri2 = 1'b0;
    wait_cyc(51);

    // door + bat, priority 1: 4-cycle half period, display rotates 2/5 every 12 cycles
    for (int k = 52; k <= 99; k++) begin
      if (k < 96) push(k, ((k - 52) / 4) % 2 == 0, (((k - 52) / 12) % 2 == 0) ? 3'd2 : 3'd5, 1'b0);
      else        push(k, 1'b0, 3'd0, 1'b0);
    end
    warn_vec = 7'b0010010;
    warn_pri1 = 1'b1;
    wait_cyc(95);
    warn_vec = 7'd0;
    warn_pri1 = 1'b0;
    wait_cyc(99);

    // ack mute, new warning unmutes, priority change restarts beep
    for (int k = 100; k <= 123; k++) begin
      if (k < 102)      push(k, 1'b1, 3'd1, 1'b0);
      else if (k < 110) push(k, 1'b0, 3'd1, 1'b1);
      else if (k < 112) push(k, 1'b1, 3'd1, 1'b0);
      else if (k < 116) push(k, 1'b1, 3'd2, 1'b0);
      else if (k < 118) push(k, 1'b0, 3'd2, 1'b0);
      else if (k < 120) push(k, 1'b1, 3'd2, 1'b0);
      else              push(k, 1'b0, 3'd0, 1'b0);
    end
    warn_vec = 7'b0000001;
    warn_pri2 = 1'b1;
    wait_cyc(101);
    ack = 1'b1;
    wait_cyc(104);
    ack = 1'b0;
    wait_cyc(109);
    warn_vec = 7'b0000011;
    wait_cyc(117);
    warn_pri1 = 1'b1;
    wait_cyc(119);
    warn_vec = 7'd0;
    warn_pri1 = 1'b0;
    warn_pri2 = 1'b0;
    wait_cyc(123);

    // displayed bit clears, then reset mid-ALERT
    for (int k = 124; k <= 150; k++) begin
      if (k < 132)      push(k, 1'b1, 3'd1, 1'b0);
      else if (k < 136) push(k, 1'b0, 3'd1, 1'b0);
      else if (k < 140) push(k, 1'b0, 3'd5, 1'b0);
      else if (k < 147) push(k, 1'b1, 3'd7, 1'b0);
      else              push(k, 1'b0, 3'd0, 1'b0);
    end
    warn_vec = 7'b1010001;
    warn_pri2 = 1'b1;
    wait_cyc(139);
    warn_vec = 7'b1000001;
    wait_cyc(146);
    rst = 1'b1;
    wait_cyc(147);
    rst = 1'b0;
    warn_vec = 7'd0;
    warn_pri2 = 1'b0;
    wait_cyc(150);

    // ack with priority-1 bat warning
    for (int k = 151; k <= 160; k++) begin
`ifdef PRI1_NOMUTE_EN
      if (k < 155)      push(k, 1'b1, 3'd5, 1'b0);
      else if (k < 159) push(k, 1'b0, 3'd5, 1'b0);
`else
      if (k < 153)      push(k, 1'b1, 3'd5, 1'b0);
      else if (k < 159) push(k, 1'b0, 3'd5, 1'b1);
`endif
      else              push(k, 1'b0, 3'd0, 1'b0);
    end
    warn_vec = 7'b0010000;
    warn_pri1 = 1'b1;
    wait_cyc(152);
    ack = 1'b1;
    wait_cyc(153);
    ack = 1'b0;
    wait_cyc(158);
    warn_vec = 7'd0;
    warn_pri1 = 1'b0;
    wait_cyc(160);

    // priority 1 rising while muted
    push(161, 1'b1, 3'd1, 1'b0);
    push(162, 1'b0, 3'd1, 1'b1);
    push(163, 1'b0, 3'd1, 1'b1);
    for (int k = 164; k <= 165; k++) begin
`ifdef PRI1_NOMUTE_EN
      push(k, 1'b1, 3'd1, 1'b0);
`else
      push(k, 1'b0, 3'd1, 1'b1);
`endif
    end
    push(166, 1'b0, 3'd0, 1'b0);
    warn_vec = 7'b0000001;
    warn_pri2 = 1'b1;
    wait_cyc(161);
    ack = 1'b1;
    wait_cyc(162);
    ack = 1'b0;
    wait_cyc(163);
    warn_pri1 = 1'b1;
    wait_cyc(165);
    warn_vec = 7'd0;
    warn_pri1 = 1'b0;
    warn_pri2 = 1'b0;

    for (int n = 0; n < 50 && sb.size() > 0; n++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d want 0", sb.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
